// File: rtl/sram_delay_line_pkg.sv
// Shared types and constants for the SRAM delay line
// and the effect stages that talk to it.
package sram_delay_line_pkg;

  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_ADDR_WIDTH  = 18;
  localparam int DEF_WAIT_CYCLES = 2;

  localparam logic SRAM_ON  = 1'b0;
  localparam logic SRAM_OFF = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/sram_delay_line_if.sv
// Sample-writer / effect-reader bus of the delay line.
// master = client side, slave = delay line.
interface sram_delay_line_if
  import sram_delay_line_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

  logic                  wr_valid;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_offset;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_done;
  logic                  ovf;

  modport master (
    output wr_valid,
    output wr_data,
    output rd_req,
    output rd_offset,
    input  rd_data,
    input  rd_done,
    input  ovf
  );

  modport slave (
    input  wr_valid,
    input  wr_data,
    input  rd_req,
    input  rd_offset,
    output rd_data,
    output rd_done,
    output ovf
  );

endinterface

// File: rtl/sram_pin_if.sv
// SRAM pin stage: registered address/controls, dq
// tristate driver and read-data capture register.
module sram_pin_if
  import sram_delay_line_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] dq_i,
  input  logic                  ce_n_i,
  input  logic                  oe_n_i,
  input  logic                  we_n_i,
  input  logic                  dq_oe_i,
  input  logic                  cap_i,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  inout  wire  [DATA_WIDTH-1:0] sram_dq_io,
  output logic                  sram_ce_n_o,
  output logic                  sram_oe_n_o,
  output logic                  sram_we_n_o,
  output logic                  sram_ub_n_o,
  output logic                  sram_lb_n_o,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] dq_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  ce_n_q;
  logic                  oe_n_q;
  logic                  we_n_q;
  logic                  dq_oe_q;

  // Pins change only at the clock edge; address and
  // write data load once per access and then hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      dq_q    <= '0;
      ce_n_q  <= SRAM_OFF;
      oe_n_q  <= SRAM_OFF;
      we_n_q  <= SRAM_OFF;
      dq_oe_q <= 1'b0;
    end else begin
      ce_n_q  <= ce_n_i;
      oe_n_q  <= oe_n_i;
      we_n_q  <= we_n_i;
      dq_oe_q <= dq_oe_i;
      if (ld_i) begin
        addr_q <= addr_i;
        dq_q   <= dq_i;
      end
    end
  end

  // Capture the bus on the last read cycle; held
  // until the next read completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (cap_i) begin
      rd_data_q <= sram_dq_io;
    end
  end

  assign sram_dq_io  = dq_oe_q ? dq_q : {DATA_WIDTH{1'bz}};
  assign sram_addr_o = addr_q;
  assign sram_ce_n_o = ce_n_q;
  assign sram_oe_n_o = oe_n_q;
  assign sram_we_n_o = we_n_q;
  assign sram_ub_n_o = ce_n_q;
  assign sram_lb_n_o = ce_n_q;
  assign rd_data_o   = rd_data_q;

endmodule

// File: rtl/sram_delay_line.sv
// Circular delay line over an async SRAM: sample
// writes at a free-running pointer, "N ago" reads.
module sram_delay_line
  import sram_delay_line_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  sram_delay_line_if.slave      bus,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  inout  wire  [DATA_WIDTH-1:0] sram_dq,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic                  sram_ub_n,
  output logic                  sram_lb_n
);

  localparam int CW =
    (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'(WAIT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] A_ONE =
    ADDR_WIDTH'(1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wp_q, wp_d;
  logic [ADDR_WIDTH-1:0] off_q, off_d;
  logic [DATA_WIDTH-1:0] wdat_q, wdat_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  wpend_q, wpend_d;
  logic                  rpend_q, rpend_d;
  logic                  ovf_q, ovf_d;
  logic                  done_q;

  logic                  wr_acc, rd_acc;
  logic                  wr_any, rd_any;
  logic                  ld;
  logic                  cap;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic                  ce_n_d, oe_n_d;
  logic                  we_n_d, dq_oe_d;
  logic [DATA_WIDTH-1:0] rd_data;

  // Request latching, arbitration (write first) and
  // pointer arithmetic; read address uses wp at grant.
  always_comb begin
    wr_acc  = bus.wr_valid && !wpend_q;
    rd_acc  = bus.rd_req && !rpend_q;
    wr_any  = wpend_q || bus.wr_valid;
    rd_any  = rpend_q || bus.rd_req;
    wdat_d  = wr_acc ? bus.wr_data : wdat_q;
    off_d   = rd_acc ? bus.rd_offset : off_q;
    wpend_d = wr_any;
    rpend_d = rd_any;
    ovf_d   = ovf_q
            || (bus.wr_valid && wpend_q)
            || (bus.rd_req && rpend_q);
    state_d = state_q;
    cnt_d   = cnt_q;
    wp_d    = wp_q;
    ld      = 1'b0;
    cap     = 1'b0;
    addr_d  = wp_q;
    unique case (state_q)
      ST_IDLE: begin
        if (wr_any) begin
          state_d = ST_WRITE;
          cnt_d   = CNT_LAST;
          ld      = 1'b1;
          addr_d  = wp_q;
        end else if (rd_any) begin
          state_d = ST_READ;
          cnt_d   = CNT_LAST;
          ld      = 1'b1;
          addr_d  = wp_q - A_ONE - off_d;
        end
      end
      ST_WRITE: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          wp_d    = wp_q + A_ONE;
          wpend_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_READ: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          cap     = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        rpend_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
    ce_n_d  = (state_d == ST_IDLE)
            ? SRAM_OFF : SRAM_ON;
    oe_n_d  = (state_d == ST_READ)
            ? SRAM_ON : SRAM_OFF;
    we_n_d  = (state_d == ST_WRITE)
            ? SRAM_ON : SRAM_OFF;
    dq_oe_d = (state_d == ST_WRITE);
  end

  // FSM, pointers, request latches and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wp_q    <= '0;
      off_q   <= '0;
      wdat_q  <= '0;
      cnt_q   <= '0;
      wpend_q <= 1'b0;
      rpend_q <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      off_q   <= off_d;
      wdat_q  <= wdat_d;
      cnt_q   <= cnt_d;
      wpend_q <= wpend_d;
      rpend_q <= rpend_d;
      ovf_q   <= ovf_d;
      done_q  <= (state_d == ST_DONE);
    end
  end

  sram_pin_if #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_pins (
    .clk         (clk),
    .rst         (rst),
    .ld_i        (ld),
    .addr_i      (addr_d),
    .dq_i        (wdat_d),
    .ce_n_i      (ce_n_d),
    .oe_n_i      (oe_n_d),
    .we_n_i      (we_n_d),
    .dq_oe_i     (dq_oe_d),
    .cap_i       (cap),
    .sram_addr_o (sram_addr),
    .sram_dq_io  (sram_dq),
    .sram_ce_n_o (sram_ce_n),
    .sram_oe_n_o (sram_oe_n),
    .sram_we_n_o (sram_we_n),
    .sram_ub_n_o (sram_ub_n),
    .sram_lb_n_o (sram_lb_n),
    .rd_data_o   (rd_data)
  );

  assign bus.rd_data = rd_data;
  assign bus.rd_done = done_q;
  assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_sram_delay_line.sv
// Bench for sram_delay_line: SRAM model, history
// model and scoreboard of read results.
module tb_sram_delay_line;

  localparam int DW    = 16;
  localparam int AW    = 10;
  localparam int WC    = 2;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_delay_line_if #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) bus ();

  wire  [DW-1:0] sram_dq;
  logic [AW-1:0] sram_addr;
  logic sram_ce_n, sram_oe_n, sram_we_n;
  logic sram_ub_n, sram_lb_n;

  sram_delay_line #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .WAIT_CYCLES (WC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .sram_addr (sram_addr),
    .sram_dq   (sram_dq),
    .sram_ce_n (sram_ce_n),
    .sram_oe_n (sram_oe_n),
    .sram_we_n (sram_we_n),
    .sram_ub_n (sram_ub_n),
    .sram_lb_n (sram_lb_n)
  );

  // Async SRAM model
  logic [DW-1:0] mem [0:DEPTH-1];
  assign sram_dq = (!sram_ce_n && !sram_oe_n)
                 ? mem[sram_addr] : {DW{1'bz}};
  always @(posedge clk)
    if (!sram_ce_n && !sram_we_n)
      mem[sram_addr] <= sram_dq;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // History model and scoreboard
  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;
  exp_t          sb[$];
  logic [DW-1:0] mm [0:DEPTH-1];
  logic [AW-1:0] mp = '0;

  function automatic logic [DW-1:0] hist(
      input logic [AW-1:0] off);
    logic [AW-1:0] idx;
    idx = mp - AW'(1) - off;
    return mm[idx];
  endfunction

  // Bus protocol monitor and read-result checker
  logic we_lo_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      check("we_oe_excl",
            32'(sram_we_n | sram_oe_n), 32'd1);
      check("wr_rd_gap",
            32'(!(we_lo_prev && !sram_oe_n)), 32'd1);
      if (bus.rd_done) begin
        if (sb.size() == 0) begin
          check("rd_unexpected", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("rd_data", 32'(bus.rd_data),
                32'(e.data));
          check("rd_latency", cyc, e.due);
        end
      end
    end
    we_lo_prev = !sram_we_n;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++)
      tick();
    check("sb_drain", sb.size(), 0);
  endtask

  task automatic wr(input logic [DW-1:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    mm[mp] = d;
    mp = mp + AW'(1);
    tick();
    bus.wr_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic rd(input logic [AW-1:0] off);
    exp_t e;
    e.data = hist(off);
    e.due  = cyc + WC + 1;
    sb.push_back(e);
    bus.rd_req    = 1'b1;
    bus.rd_offset = off;
    tick();
    bus.rd_req = 1'b0;
    drain();
  endtask

  task automatic wr_rd(input logic [DW-1:0] d,
                       input logic [AW-1:0] off);
    exp_t e;
    mm[mp] = d;
    mp = mp + AW'(1);
    e.data = hist(off);
    e.due  = cyc + 2 * (WC + 1);
    sb.push_back(e);
    bus.wr_valid  = 1'b1;
    bus.wr_data   = d;
    bus.rd_req    = 1'b1;
    bus.rd_offset = off;
    tick();
    bus.wr_valid = 1'b0;
    bus.rd_req   = 1'b0;
    drain();
  endtask

  task automatic chk_idle(input string tag);
    check({tag, "_ctrl"},
          32'({sram_ce_n, sram_oe_n, sram_we_n,
               sram_ub_n, sram_lb_n}), 32'h1f);
    check({tag, "_addr"}, 32'(sram_addr), 32'd0);
    check({tag, "_done"}, 32'(bus.rd_done), 32'd0);
    check({tag, "_ovf"}, 32'(bus.ovf), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] off;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    bus.rd_req    = 1'b0;
    bus.rd_offset = '0;
    rst = 1'b1;
    repeat (3) tick();
    chk_idle("rst");
    check("rst_rd_data", 32'(bus.rd_data), 32'd0);
    rst = 1'b0;
    tick();

    // Reset in the middle of a write
    bus.wr_valid = 1'b1;
    bus.wr_data  = 16'h5555;
    tick();
    bus.wr_valid = 1'b0;
    check("wr_ctrl",
          32'({sram_ce_n, sram_oe_n, sram_we_n,
               sram_ub_n, sram_lb_n}), 32'h08);
    rst = 1'b1;
    #1;
    chk_idle("rst_mid");
    tick();
    rst = 1'b0;
    tick();

    // Basic write/read
    wr(16'h1234);
    wr(16'hABCD);
    rd(0);
    rd(1);

    // Simultaneous strobes: write first
    wr_rd(16'h7FFF, 0);
    check("ovf_clear", 32'(bus.ovf), 32'd0);

    // Overflow: second strobe while pending
    bus.wr_valid = 1'b1;
    bus.wr_data  = 16'h1111;
    mm[mp] = 16'h1111;
    mp = mp + AW'(1);
    tick();
    bus.wr_data = 16'h2222;
    tick();
    bus.wr_valid = 1'b0;
    tick();
    tick();
    check("ovf_set", 32'(bus.ovf), 32'd1);
    rd(0);
    rd(1);

    // Wrap the buffer with an incrementing count
    for (int i = 0; i < DEPTH + 2; i++)
      wr(DW'(i));
    rd(3);
    rd(0);
    rd(8);
    rd(AW'(DEPTH - 1));
    for (int i = 0; i < 4; i++) begin
      off = AW'($urandom_range(0, DEPTH - 1));
      rd(off);
    end
    check("ovf_sticky", 32'(bus.ovf), 32'd1);
    check("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
